// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain driver: session states, byte width
// and the helper that sizes each byte (the final byte may be partial).
// Optional readback path is enabled with SCAN_CHAIN_DRIVER_READBACK_EN.
package scan_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_IDX_W = $clog2(BYTE_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } scan_state_e;

  // Number of bits to shift for the next byte: a full byte, or whatever is
  // left of the chain when fewer than eight bits remain.
  function automatic logic [BIT_IDX_W-1:0] byte_bit_count(input int unsigned remaining);
    if (remaining >= BYTE_W) begin
      return BIT_IDX_W'(BYTE_W);
    end
    return BIT_IDX_W'(remaining);
  endfunction

endpackage

// File: rtl/scan_byte_serializer.sv
// Per-byte serializer: holds the current load byte, presents its bits LSB
// first and (when SCAN_CHAIN_DRIVER_READBACK_EN is defined) packs the bits
// returned by the chain into a capture byte, LSB first, upper bits zero.
module scan_byte_serializer
  import scan_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BYTE_W-1:0]    load_byte,
  input  logic [BIT_IDX_W-1:0] load_nbits,
  input  logic                 shift,
  input  logic                 chain_out,
  output logic                 ser_bit,
  output logic                 last_bit,
  output logic [BYTE_W-1:0]    cap_next
);

  logic [BYTE_W-1:0]    data_q, data_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic [BIT_IDX_W-1:0] nbits_q, nbits_d;

  // Next byte/index: load restarts the byte, each shift consumes one bit.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    nbits_d = nbits_q;
    if (load) begin
      data_d  = load_byte;
      idx_d   = '0;
      nbits_d = load_nbits;
    end else if (shift) begin
      data_d = data_q >> 1;
      idx_d  = idx_q + BIT_IDX_W'(1);
    end
  end

  // Byte shift register, bit index and per-byte bit budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      idx_q   <= '0;
      nbits_q <= '0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      nbits_q <= nbits_d;
    end
  end

  assign ser_bit  = data_q[0];
  assign last_bit = (idx_q == (nbits_q - BIT_IDX_W'(1)));

`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
  logic [BYTE_W-1:0] cap_q, cap_d;

  // Capture: cleared on load so the unused upper bits of a short byte read 0.
  always_comb begin
    cap_d = cap_q;
    if (load) begin
      cap_d = '0;
    end else if (shift) begin
      cap_d[idx_q[2:0]] = chain_out;
    end
  end

  // Capture byte register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  // Includes the sample taken on the byte's final shift edge.
  assign cap_next = cap_d;
`else
  logic unused_chain_out;
  assign unused_chain_out = chain_out;
  assign cap_next         = '0;
`endif

endmodule

// File: rtl/scan_chain_driver.sv
// Scan-chain driver: streams host bytes into a processor scan chain,
// optionally returns the captured chain contents, then releases the
// processor. Readback (DRAIN state, rd_* path) exists only when
// SCAN_CHAIN_DRIVER_READBACK_EN is defined; otherwise rd_valid/rd_data are 0.
module scan_chain_driver
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 288
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run_after,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              scan_enable,
  output logic              chain_in,
  input  logic              chain_out,
  output logic              proc_en,
  input  logic              halt,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  scan_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 run_after_q, run_after_d;
  logic                 proc_en_q, proc_en_d;
  logic [CNT_W-1:0]     remaining;
  logic [BIT_IDX_W-1:0] load_nbits;
  logic                 ser_load, ser_shift, ser_bit, ser_last;
  logic [BYTE_W-1:0]    cap_next;
  logic                 unused_inputs;

  assign remaining  = LEN_C - cnt_q;
  assign load_nbits = byte_bit_count(32'(remaining));
  assign ser_load   = (state_q == ST_LOAD) && wr_valid;
  assign ser_shift  = (state_q == ST_SHIFT);

  scan_byte_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_byte  (wr_data),
    .load_nbits (load_nbits),
    .shift      (ser_shift),
    .chain_out  (chain_out),
    .ser_bit    (ser_bit),
    .last_bit   (ser_last),
    .cap_next   (cap_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so a start during a
  // session or coincident with done is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   if (wr_valid) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (ser_last) begin
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
          state_d = ST_DRAIN;
`else
          state_d = ((cnt_q + CNT_W'(1)) == LEN_C) ? ST_FINISH : ST_LOAD;
`endif
        end
      end
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
      ST_DRAIN:  if (rd_ready) state_d = (cnt_q == LEN_C) ? ST_FINISH : ST_LOAD;
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Session bookkeeping: bit counter (saturates at CHAIN_LEN), latched
  // run_after, and the processor enable that is held low for the session.
  always_comb begin
    cnt_d       = cnt_q;
    run_after_d = run_after_q;
    proc_en_d   = proc_en_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          run_after_d = run_after;
          proc_en_d   = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_SHIFT:  if (cnt_q != LEN_C) cnt_d = cnt_q + CNT_W'(1);
      ST_FINISH: proc_en_d = run_after_q;
      default: ;
    endcase
  end

  // Session bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      run_after_q <= 1'b0;
      proc_en_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      run_after_q <= run_after_d;
      proc_en_q   <= proc_en_d;
    end
  end

`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
  logic              rd_valid_q, rd_valid_d;
  logic [BYTE_W-1:0] rd_data_q, rd_data_d;

  // Readback byte is registered on the byte's last shift and held until taken.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (ser_shift && ser_last) begin
      rd_valid_d = 1'b1;
      rd_data_d  = cap_next;
    end else if ((state_q == ST_DRAIN) && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  // Readback output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign unused_inputs = halt;
`else
  assign rd_valid      = 1'b0;
  assign rd_data       = '0;
  assign unused_inputs = ^{halt, rd_ready, cap_next};
`endif

  // Outputs decoded from state; scan_enable only in SHIFT so the chain
  // holds whenever the host stalls. halt is status only.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    wr_ready    = (state_q == ST_LOAD);
    scan_enable = (state_q == ST_SHIFT);
    done        = (state_q == ST_FINISH);
    chain_in    = (state_q == ST_SHIFT) && ser_bit;
    proc_en     = proc_en_q;
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: a 16-bit and a 12-bit chain instance, each
// looped through an emulated processor scan chain. Readback expectations
// are exercised when SCAN_CHAIN_DRIVER_READBACK_EN is defined.
module tb_scan_chain_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s[2], run_after_s[2], wr_valid_s[2], rd_ready_s[2], halt_s[2];
  logic [7:0] wr_data_s[2];
  logic       wr_ready_w[2], rd_valid_w[2], scan_enable_w[2], chain_in_w[2];
  logic       chain_out_w[2], proc_en_w[2], busy_w[2], done_w[2];
  logic [7:0] rd_data_w[2];

  scan_chain_driver #(.CHAIN_LEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_s[0]), .run_after(run_after_s[0]),
    .wr_data(wr_data_s[0]), .wr_valid(wr_valid_s[0]), .wr_ready(wr_ready_w[0]),
    .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .rd_ready(rd_ready_s[0]),
    .scan_enable(scan_enable_w[0]), .chain_in(chain_in_w[0]), .chain_out(chain_out_w[0]),
    .proc_en(proc_en_w[0]), .halt(halt_s[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  scan_chain_driver #(.CHAIN_LEN(12)) u_dut12 (
    .clk(clk), .rst(rst), .start(start_s[1]), .run_after(run_after_s[1]),
    .wr_data(wr_data_s[1]), .wr_valid(wr_valid_s[1]), .wr_ready(wr_ready_w[1]),
    .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .rd_ready(rd_ready_s[1]),
    .scan_enable(scan_enable_w[1]), .chain_in(chain_in_w[1]), .chain_out(chain_out_w[1]),
    .proc_en(proc_en_w[1]), .halt(halt_s[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  function automatic int len_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
  localparam int RD_BYTES = 2;
`else
  localparam int RD_BYTES = 0;
`endif

  // Emulated processor scan chains: scan_out is bit 0, scan_in enters at the top.
  logic [15:0] sr[2];
  logic [15:0] preload_val[2];
  logic        preload_req[2];

  function automatic logic [15:0] chain_shift(input logic [15:0] v, input logic b, input int len);
    logic [15:0] r;
    r = v >> 1;
    r[len-1] = b;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (preload_req[d]) sr[d] <= preload_val[d];
      else if (scan_enable_w[d]) sr[d] <= chain_shift(sr[d], chain_in_w[d], len_of(d));
    end
  end
  assign chain_out_w[0] = sr[0][0];
  assign chain_out_w[1] = sr[1][0];

  // Behavioural model: expected chain bit stream and readback bytes per DUT.
  logic [15:0] chain_img[2];
  logic [15:0] exp_in_v[2];
  logic [7:0]  exp_rd[2][2];
  logic [15:0] obs_in[2];
  logic [7:0]  obs_rd[2][2];
  int          shift_cnt[2], rd_cnt[2], done_cnt[2];

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (scan_enable_w[d]) begin
          check($sformatf("dut%0d busy_while_shift", d), busy_w[d], 1);
          if (shift_cnt[d] >= len_of(d)) begin
            check($sformatf("dut%0d shift_over", d), shift_cnt[d], len_of(d) - 1);
          end else begin
            check($sformatf("dut%0d chain_in[%0d]", d, shift_cnt[d]), chain_in_w[d],
                  exp_in_v[d][shift_cnt[d]]);
            obs_in[d][shift_cnt[d]] = chain_in_w[d];
          end
          shift_cnt[d]++;
        end
        if (busy_w[d]) check($sformatf("dut%0d proc_en_in_session", d), proc_en_w[d], 0);
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
        if (rd_valid_w[d] && rd_ready_s[d]) begin
          if (rd_cnt[d] < 2) begin
            check($sformatf("dut%0d rd_data[%0d]", d, rd_cnt[d]), rd_data_w[d], exp_rd[d][rd_cnt[d]]);
            obs_rd[d][rd_cnt[d]] = rd_data_w[d];
          end else begin
            check($sformatf("dut%0d rd_extra", d), rd_cnt[d], 1);
          end
          rd_cnt[d]++;
        end
`else
        check($sformatf("dut%0d rd_valid_tied", d), rd_valid_w[d], 0);
        check($sformatf("dut%0d rd_data_tied", d), rd_data_w[d], 0);
`endif
        if (done_w[d]) done_cnt[d]++;
      end
    end
  endtask

  task automatic check_reset_outputs(input int d);
    check($sformatf("dut%0d rst scan_enable", d), scan_enable_w[d], 0);
    check($sformatf("dut%0d rst chain_in", d), chain_in_w[d], 0);
    check($sformatf("dut%0d rst proc_en", d), proc_en_w[d], 0);
    check($sformatf("dut%0d rst busy", d), busy_w[d], 0);
    check($sformatf("dut%0d rst done", d), done_w[d], 0);
    check($sformatf("dut%0d rst wr_ready", d), wr_ready_w[d], 0);
    check($sformatf("dut%0d rst rd_valid", d), rd_valid_w[d], 0);
    check($sformatf("dut%0d rst rd_data", d), rd_data_w[d], 0);
  endtask

  task automatic preload(input int d, input logic [15:0] v);
    preload_val[d] = v;
    preload_req[d] = 1'b1;
    tick();
    preload_req[d] = 1'b0;
    chain_img[d]   = v;
  endtask

  task automatic prepare_model(input int d, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] bits;
    int          idx;
    bits = {b1, b0};
    exp_in_v[d] = '0;
    for (int k = 0; k < len_of(d); k++) exp_in_v[d][k] = bits[k];
    for (int j = 0; j < 2; j++) begin
      for (int b = 0; b < 8; b++) begin
        idx = 8 * j + b;
        exp_rd[d][j][b] = (idx < len_of(d)) ? chain_img[d][idx] : 1'b0;
      end
    end
    shift_cnt[d] = 0;
    rd_cnt[d]    = 0;
    done_cnt[d]  = 0;
    obs_in[d]    = '0;
    obs_rd[d][0] = '0;
    obs_rd[d][1] = '0;
  endtask

  task automatic pulse_start(input int d, input logic ra);
    start_s[d]     = 1'b1;
    run_after_s[d] = ra;
    tick();
    start_s[d]     = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    logic got;
    got = 1'b0;
    wr_valid_s[d] = 1'b1;
    wr_data_s[d]  = b;
    for (int i = 0; i < 200 && !got; i++) begin
      if (wr_ready_w[d]) got = 1'b1;
      tick();
    end
    wr_valid_s[d] = 1'b0;
    check($sformatf("dut%0d wr_accept", d), got, 1);
  endtask

  task automatic run_session(input int d, input logic ra, input logic [7:0] b0, input logic [7:0] b1,
                             input int stall, input bit start_busy, input bit start_at_done);
    logic seen;
    prepare_model(d, b0, b1);
    rd_ready_s[d] = (stall == 0);
    pulse_start(d, ra);
    send_byte(d, b0);
    if (stall > 0) begin
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        if (rd_valid_w[d]) seen = 1'b1;
        else tick();
      end
      check($sformatf("dut%0d rd_valid_seen", d), seen, 1);
      for (int i = 0; i < stall; i++) begin
        check($sformatf("dut%0d rd_stall scan_enable", d), scan_enable_w[d], 0);
        tick();
      end
      check($sformatf("dut%0d rd_stall shift_cnt", d), shift_cnt[d], 8);
`endif
      rd_ready_s[d] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        if (wr_ready_w[d]) seen = 1'b1;
        else tick();
      end
      check($sformatf("dut%0d wr_ready_seen", d), seen, 1);
      for (int i = 0; i < stall; i++) begin
        start_s[d] = start_busy && (i == 0);
        check($sformatf("dut%0d wr_stall scan_enable", d), scan_enable_w[d], 0);
        tick();
      end
      start_s[d] = 1'b0;
      check($sformatf("dut%0d wr_stall shift_cnt", d), shift_cnt[d], 8);
    end
    send_byte(d, b1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done_w[d]) seen = 1'b1;
      else tick();
    end
    check($sformatf("dut%0d done_seen", d), done_w[d], 1);
    start_s[d] = start_at_done;
    tick();
    start_s[d] = 1'b0;
    check($sformatf("dut%0d proc_en_after", d), proc_en_w[d], ra);
    repeat (3) tick();
    check($sformatf("dut%0d idle_after", d), busy_w[d], 0);
    check($sformatf("dut%0d done_count", d), done_cnt[d], 1);
    check($sformatf("dut%0d shift_total", d), shift_cnt[d], len_of(d));
    check($sformatf("dut%0d rd_total", d), rd_cnt[d], RD_BYTES);
    chain_img[d] = exp_in_v[d];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; run_after_s[d] = 1'b0; wr_valid_s[d] = 1'b0;
      wr_data_s[d] = 8'h00; rd_ready_s[d] = 1'b1; halt_s[d] = 1'b0;
      preload_req[d] = 1'b0; preload_val[d] = '0; chain_img[d] = '0;
      exp_in_v[d] = '0; shift_cnt[d] = 0; rd_cnt[d] = 0; done_cnt[d] = 0;
    end
    fork
      compare_loop();
    join_none
    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst = 1'b1;
    tick();

    preload(0, 16'h1234);
    preload(1, 16'h0FFF);

    // 16-bit chain, 0xA5 0x3C, run_after=1.
    run_session(0, 1'b1, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    $display("session A: dut16 chain_in=0x%04h", obs_in[0]);
    check("dut0 A chain_in_seq", obs_in[0], 16'h3CA5);
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
    check("dut0 A rd0", obs_rd[0][0], 8'h34);
    check("dut0 A rd1", obs_rd[0][1], 8'h12);
`endif

    // Stalled host, stray start while busy and at done, halt asserted.
    halt_s[0] = 1'b1;
    run_session(0, 1'b0, 8'h0F, 8'hF0, 20, 1'b1, 1'b1);
    halt_s[0] = 1'b0;
    $display("session B: dut16 chain_in=0x%04h", obs_in[0]);
    check("dut0 B chain_in_seq", obs_in[0], 16'hF00F);
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
    check("dut0 B rd0", obs_rd[0][0], 8'hA5);
    check("dut0 B rd1", obs_rd[0][1], 8'h3C);
`endif

    // 12-bit chain: partial final byte.
    run_session(1, 1'b1, 8'hFF, 8'hFF, 0, 1'b0, 1'b0);
    $display("session C: dut12 shifts=%0d", shift_cnt[1]);
    check("dut1 C shifts", shift_cnt[1], 12);
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
    check("dut1 C rd0", obs_rd[1][0], 8'hFF);
    check("dut1 C rd1", obs_rd[1][1], 8'h0F);
`endif

    // Reset in the middle of SHIFT, then a clean session.
    prepare_model(0, 8'h5A, 8'h00);
    pulse_start(0, 1'b1);
    send_byte(0, 8'h5A);
    repeat (3) tick();
    check("dut0 in_shift_before_rst", scan_enable_w[0], 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("session D: reset during shift applied");
    preload(0, 16'hBEEF);
    run_session(0, 1'b1, 8'h81, 8'h7E, 0, 1'b0, 1'b0);
    $display("session D: dut16 chain_in=0x%04h", obs_in[0]);
    check("dut0 D chain_in_seq", obs_in[0], 16'h7E81);
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
    check("dut0 D rd0", obs_rd[0][0], 8'hEF);
    check("dut0 D rd1", obs_rd[0][1], 8'hBE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
